// File: rtl/seg7_event_decoder.sv
// seg7_event_decoder
// Receiver for the active-low 7-segment bus {G,F,E,D,C,B,A} driven by the
// single-digit inc/dec counter. The bus is synchronised bit by bit and
// stability-filtered. Each newly accepted pattern is then decoded and
// classified as one of: a step up, a step down, a jump, a blank display or an
// unrecognised pattern.

// One synchroniser lane. It resets to the unlit (logic 1) level so that a
// freshly reset receiver sees a blank display.
module seg7_sync_bit (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic d,
  output logic q
);
  logic meta;

  // Two-flop synchroniser for one asynchronous segment line
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      meta <= 1'b1;
      q    <= 1'b1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

module seg7_event_decoder #(
  parameter int STABLE_TIME = 250_000,
  parameter int CNT_WIDTH   = 18
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic [6:0] i_Segments,
  output logic [3:0] o_Digit,
  output logic       o_Digit_Valid,
  output logic       o_Invalid,
  output logic       o_Inc_Pulse,
  output logic       o_Dec_Pulse,
  output logic       o_Jump_Pulse,
  output logic [7:0] o_Error_Count
);
  localparam int                   NUM_SEGS  = 7;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = CNT_WIDTH'(STABLE_TIME - 1);
  localparam logic [6:0]           PAT_BLANK = 7'h7F;

  typedef enum logic [1:0] {IDLE, TRACK, FAULT} state_t;

  // Result of decoding one segment pattern
  typedef struct packed {
    logic       is_digit;
    logic       is_blank;
    logic [3:0] digit;
  } decode_t;

  // Active-low pattern to digit. Anything that is not 0-9 and not blank is
  // reported as neither digit nor blank, which makes it invalid.
  function automatic decode_t decode_pat(input logic [6:0] pat);
    decode_t r;
    r          = '0;
    r.is_digit = 1'b1;
    case (pat)
      7'b1000000: r.digit = 4'd0;
      7'b1111001: r.digit = 4'd1;
      7'b0100100: r.digit = 4'd2;
      7'b0110000: r.digit = 4'd3;
      7'b0011001: r.digit = 4'd4;
      7'b0010010: r.digit = 4'd5;
      7'b0000010: r.digit = 4'd6;
      7'b1111000: r.digit = 4'd7;
      7'b0000000: r.digit = 4'd8;
      7'b0010000: r.digit = 4'd9;
      default:    r.is_digit = 1'b0;
    endcase
    r.is_blank = (pat == PAT_BLANK);
    return r;
  endfunction

  logic [NUM_SEGS-1:0]  seg_sync;
  logic [NUM_SEGS-1:0]  cand;
  logic [NUM_SEGS-1:0]  acc;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 accept;
  decode_t              cand_dec;
  logic [3:0]           digit_up;
  logic [3:0]           digit_dn;
  state_t               state;

  for (genvar i = 0; i < NUM_SEGS; i++) begin : g_sync
    seg7_sync_bit u_sync (
      .i_Clk  (i_Clk),
      .i_Rst_L(i_Rst_L),
      .d      (i_Segments[i]),
      .q      (seg_sync[i])
    );
  end

  // Stability filter: any change restarts the count, and a settled value
  // holds the count at its maximum
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      cand <= PAT_BLANK;
      cnt  <= '0;
    end else if (seg_sync != cand) begin
      cand <= seg_sync;
      cnt  <= '0;
    end else if (cnt != CNT_MAX) begin
      cnt  <= cnt + CNT_WIDTH'(1);
    end
  end

  // A settled candidate is committed only if it differs from what is already
  // accepted. A glitch that returns to the old value therefore causes no event.
  assign accept   = (cnt == CNT_MAX) && (cand != acc);
  assign cand_dec = decode_pat(cand);

  // Neighbours of the digit currently held, wrapping within 0-9
  assign digit_up = (o_Digit == 4'd9) ? 4'd0 : o_Digit + 4'd1;
  assign digit_dn = (o_Digit == 4'd0) ? 4'd9 : o_Digit - 4'd1;

  // Event FSM: commits the accepted pattern, classifies digit steps into
  // one-cycle pulses and counts unrecognised patterns
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state         <= IDLE;
      acc           <= PAT_BLANK;
      o_Digit       <= 4'd0;
      o_Digit_Valid <= 1'b0;
      o_Invalid     <= 1'b0;
      o_Inc_Pulse   <= 1'b0;
      o_Dec_Pulse   <= 1'b0;
      o_Jump_Pulse  <= 1'b0;
      o_Error_Count <= 8'd0;
    end else begin
      o_Inc_Pulse  <= 1'b0;
      o_Dec_Pulse  <= 1'b0;
      o_Jump_Pulse <= 1'b0;
      if (accept) begin
        acc <= cand;
        if (cand_dec.is_digit) begin
          state         <= TRACK;
          o_Digit       <= cand_dec.digit;
          o_Digit_Valid <= 1'b1;
          o_Invalid     <= 1'b0;
          // Only a digit-to-digit transition is an event. The first digit
          // after blank, fault or reset only re-establishes tracking.
          if (state == TRACK) begin
            if (cand_dec.digit == digit_up)      o_Inc_Pulse  <= 1'b1;
            else if (cand_dec.digit == digit_dn) o_Dec_Pulse  <= 1'b1;
            else                                 o_Jump_Pulse <= 1'b1;
          end
        end else if (cand_dec.is_blank) begin
          state         <= IDLE;
          o_Digit       <= 4'd0;
          o_Digit_Valid <= 1'b0;
          o_Invalid     <= 1'b0;
        end else begin
          // o_Digit keeps the last good digit for post-mortem inspection
          state         <= FAULT;
          o_Digit_Valid <= 1'b0;
          o_Invalid     <= 1'b1;
          if (o_Error_Count != 8'hFF) o_Error_Count <= o_Error_Count + 8'd1;
        end
      end
    end
  end
endmodule

// File: tb/tb_seg7_event_decoder.sv
// Scoreboard bench for seg7_event_decoder. Stimulus is a sequence of
// "holds": a pattern is driven for n cycles. A reference model predicts
// what each hold does to the outputs, and when. A separate monitor pops the
// predictions whenever the outputs change or a pulse fires.
module tb_seg7_event_decoder;
  localparam int ST  = 50;
  localparam int LAT = ST + 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] seg;
  logic [3:0] o_Digit;
  logic       o_Digit_Valid, o_Invalid, o_Inc_Pulse, o_Dec_Pulse, o_Jump_Pulse;
  logic [7:0] o_Error_Count;

  seg7_event_decoder #(.STABLE_TIME(ST), .CNT_WIDTH(18)) dut (
    .i_Clk        (clk),
    .i_Rst_L      (rst_n),
    .i_Segments   (seg),
    .o_Digit      (o_Digit),
    .o_Digit_Valid(o_Digit_Valid),
    .o_Invalid    (o_Invalid),
    .o_Inc_Pulse  (o_Inc_Pulse),
    .o_Dec_Pulse  (o_Dec_Pulse),
    .o_Jump_Pulse (o_Jump_Pulse),
    .o_Error_Count(o_Error_Count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int digit;
    bit valid, invalid, inc, dec, jump;
    int err;
    int cyc;
  } snap_t;

  snap_t      exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [6:0] seg_tab [0:9];
  logic [6:0] prev_pin;

  // Reference model state: what the display should currently show
  logic [6:0] m_acc;
  int         m_digit, m_err;
  bit         m_valid, m_invalid;

  always @(posedge clk) cyc <= cyc + 1;

  // Returns 0-9 for a digit pattern, 10 for blank, and -1 otherwise
  function automatic int lookup(input logic [6:0] p);
    int r = -1;
    for (int i = 0; i < 10; i++) if (seg_tab[i] == p) r = i;
    if (p == 7'h7F) r = 10;
    return r;
  endfunction

  function automatic logic [6:0] rand_invalid();
    logic [6:0] p;
    do p = 7'($urandom_range(0, 127)); while (lookup(p) != -1);
    return p;
  endfunction

  task automatic model_reset();
    m_acc = 7'h7F; m_digit = 0; m_err = 0; m_valid = 0; m_invalid = 0;
  endtask

  // A hold of at least ST cycles whose pattern differs from the accepted one
  // becomes visible LAT cycles after it was first driven
  task automatic model_hold(input logic [6:0] pat, input int n, input int k);
    snap_t e;
    int d, pd, pe;
    bit pv, pi;
    if (n >= ST && pat != m_acc) begin
      pd = m_digit; pv = m_valid; pi = m_invalid; pe = m_err;
      m_acc = pat;
      d = lookup(pat);
      e.inc = 0; e.dec = 0; e.jump = 0;
      if (d >= 0 && d <= 9) begin
        if (m_valid) begin
          if (d == (m_digit + 1) % 10)      e.inc = 1;
          else if (d == (m_digit + 9) % 10) e.dec = 1;
          else                              e.jump = 1;
        end
        m_digit = d; m_valid = 1; m_invalid = 0;
      end else if (d == 10) begin
        m_digit = 0; m_valid = 0; m_invalid = 0;
      end else begin
        m_valid = 0; m_invalid = 1;
        if (m_err < 255) m_err++;
      end
      e.digit = m_digit; e.valid = m_valid; e.invalid = m_invalid;
      e.err = m_err; e.cyc = k + LAT;
      if (pd != m_digit || pv != m_valid || pi != m_invalid || pe != m_err ||
          e.inc || e.dec || e.jump)
        exp_q.push_back(e);
    end
  endtask

  // Called at #1 after a posedge; returns at #1 after the last held edge
  task automatic hold(input logic [6:0] pat, input int n);
    int k;
    seg = pat; k = cyc; prev_pin = pat;
    model_hold(pat, n, k);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_digit"}, int'(o_Digit), 0);
    chk({tag, "_valid"}, int'(o_Digit_Valid), 0);
    chk({tag, "_invalid"}, int'(o_Invalid), 0);
    chk({tag, "_inc"}, int'(o_Inc_Pulse), 0);
    chk({tag, "_dec"}, int'(o_Dec_Pulse), 0);
    chk({tag, "_jump"}, int'(o_Jump_Pulse), 0);
    chk({tag, "_errcnt"}, int'(o_Error_Count), 0);
  endtask

  // Wait (bounded) for all predicted events, then realign to edge+1
  task automatic drain(input string tag);
    int t = 0;
    while (exp_q.size() > 0 && t < 500) begin @(posedge clk); t++; end
    @(posedge clk); #1;
    chk({tag, "_pending_events"}, exp_q.size(), 0);
  endtask

  // Monitor: any level change or any pulse is one DUT event to score
  initial begin
    snap_t a, e;
    bit trig;
    int pd = 0, pe = 0;
    bit pv = 0, pi = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pd = 0; pv = 0; pi = 0; pe = 0;
      end else begin
        a.digit = int'(o_Digit); a.valid = o_Digit_Valid; a.invalid = o_Invalid;
        a.inc = o_Inc_Pulse; a.dec = o_Dec_Pulse; a.jump = o_Jump_Pulse;
        a.err = int'(o_Error_Count); a.cyc = cyc;
        trig = (a.digit != pd) || (a.valid != pv) || (a.invalid != pi) ||
               (a.err != pe) || a.inc || a.dec || a.jump;
        if (trig) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: cyc=%0d d=%0d v=%0b inv=%0b inc=%0b dec=%0b jmp=%0b err=%0d, expected no event",
                     a.cyc, a.digit, a.valid, a.invalid, a.inc, a.dec, a.jump, a.err);
          end else begin
            e = exp_q.pop_front();
            if (a.cyc != e.cyc || a.digit != e.digit || a.valid != e.valid ||
                a.invalid != e.invalid || a.inc != e.inc || a.dec != e.dec ||
                a.jump != e.jump || a.err != e.err)
            begin
              errors++;
              $display("FAIL event: got cyc=%0d d=%0d v=%0b inv=%0b inc=%0b dec=%0b jmp=%0b err=%0d; expected cyc=%0d d=%0d v=%0b inv=%0b inc=%0b dec=%0b jmp=%0b err=%0d",
                       a.cyc, a.digit, a.valid, a.invalid, a.inc, a.dec, a.jump, a.err,
                       e.cyc, e.digit, e.valid, e.invalid, e.inc, e.dec, e.jump, e.err);
            end
          end
        end
        pd = a.digit; pv = a.valid; pi = a.invalid; pe = a.err;
      end
    end
  end

  initial begin
    logic [6:0] p;
    int r, n;
    seg_tab[0] = 7'b1000000; seg_tab[1] = 7'b1111001; seg_tab[2] = 7'b0100100;
    seg_tab[3] = 7'b0110000; seg_tab[4] = 7'b0011001; seg_tab[5] = 7'b0010010;
    seg_tab[6] = 7'b0000010; seg_tab[7] = 7'b1111000; seg_tab[8] = 7'b0000000;
    seg_tab[9] = 7'b0010000;

    rst_n = 1'b0; seg = 7'h7F; prev_pin = 7'h7F;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset_init");
    rst_n = 1'b1;

    // First digit, then the inc/dec/wrap steps
    hold(seg_tab[0], 100);
    hold(seg_tab[3], 100);
    hold(seg_tab[4], 100);
    hold(seg_tab[9], 100);
    hold(seg_tab[0], 100);
    hold(seg_tab[9], 100);
    // Short excursion is discarded; 2 -> 7 is a jump
    hold(seg_tab[5], 100);
    hold(seg_tab[6], 30);
    hold(seg_tab[5], 100);
    hold(seg_tab[2], 100);
    hold(seg_tab[7], 100);
    // Only segment D lit, then recovery without a pulse
    hold(7'b1110111, 100);
    hold(seg_tab[5], 100);
    // Acceptance boundary: ST-1 is rejected, ST is accepted
    hold(seg_tab[6], ST - 1);
    hold(seg_tab[1], ST);
    hold(seg_tab[3], ST + 5);

    // Random holds of digits, blanks and junk with mixed lengths
    for (int i = 0; i < 200; i++) begin
      do begin
        r = $urandom_range(0, 19);
        if (r < 12)      p = seg_tab[$urandom_range(0, 9)];
        else if (r < 15) p = 7'h7F;
        else             p = rand_invalid();
      end while (p == prev_pin);
      r = $urandom_range(0, 9);
      if (r == 0)      n = ST - 1;
      else if (r == 1) n = ST;
      else if (r < 4)  n = $urandom_range(1, ST - 2);
      else             n = $urandom_range(ST + 1, ST + 40);
      hold(p, n);
    end

    // Error counter saturation
    if (prev_pin == seg_tab[8]) hold(seg_tab[1], ST + 10);
    hold(seg_tab[8], 100);
    for (int i = 0; i < 300; i++) begin
      hold(7'b1110111, ST);
      hold(7'h7F, ST);
    end
    // Blank clears the digit; the next digit is not an event
    hold(seg_tab[4], 100);
    hold(7'h7F, 100);
    hold(seg_tab[5], 100);
    drain("pre_reset");

    // Asynchronous reset in the middle of filtering
    seg = seg_tab[3]; prev_pin = seg_tab[3];
    repeat (27) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset("reset_async");
    seg = 7'h7F; prev_pin = 7'h7F;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    hold(seg_tab[6], 100);
    drain("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
